// File: rtl/palette_pkg.sv
// Shared types and reset table for the programmable colour look-up table.
package palette_pkg;

    localparam int unsigned DEF_CH_W           = 8;
    localparam int unsigned DEF_ENTRIES        = 16;
    localparam int unsigned LIVE_INDEX_DEFAULT = 5;

    typedef struct packed {
        logic [DEF_CH_W-1:0] red;
        logic [DEF_CH_W-1:0] green;
        logic [DEF_CH_W-1:0] blue;
    } rgb_t;

    localparam rgb_t [0:DEF_ENTRIES-1] DEFAULT_PALETTE = {
        24'hffc0cb, 24'h000000, 24'hffffff, 24'h898989,
        24'hcfcfcd, 24'h000000, 24'hd0d20e, 24'hc7f8f8,
        24'h0313ff, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    // Entries beyond the 16-entry table reset to black.
    function automatic rgb_t default_rgb(input int unsigned idx);
        rgb_t c;
        c = '0;
        if (idx < DEF_ENTRIES) begin
            c = DEFAULT_PALETTE[idx[3:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/palette_lut_blink_timer.sv
// Frame counter that toggles blink_phase every BLINK_FRAMES frame_start pulses.
module blink_timer #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic blink_phase
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (count == LAST) begin
                count       <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/palette_lut.sv
// Register-based palette with a per-frame live slot, blink flags and a 2-stage lookup.
module palette_lut
    import palette_pkg::*;
#(
    parameter int unsigned INDEX_W      = 4,
    parameter int unsigned CH_W         = 8,
    parameter int unsigned LIVE_INDEX   = LIVE_INDEX_DEFAULT,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [INDEX_W-1:0] pix_index,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_addr,
    input  logic [CH_W-1:0]    wr_red,
    input  logic [CH_W-1:0]    wr_green,
    input  logic [CH_W-1:0]    wr_blue,
    input  logic               wr_blink,
    input  logic [CH_W-1:0]    live_red,
    input  logic [CH_W-1:0]    live_green,
    input  logic [CH_W-1:0]    live_blue,
    output logic               out_valid,
    output logic [CH_W-1:0]    red,
    output logic [CH_W-1:0]    green,
    output logic [CH_W-1:0]    blue
);

    localparam int unsigned DEPTH = 2 ** INDEX_W;
    localparam logic [INDEX_W-1:0] LIVE_SLOT = INDEX_W'(LIVE_INDEX);

    typedef struct packed {
        logic [CH_W-1:0] red;
        logic [CH_W-1:0] green;
        logic [CH_W-1:0] blue;
    } colour_t;

    // Narrow channels keep the MSBs, wide channels pad zeros below the 8-bit value.
    function automatic logic [CH_W-1:0] fit_channel(input logic [DEF_CH_W-1:0] v);
        logic [DEF_CH_W+CH_W-1:0] wide;
        wide = {v, {CH_W{1'b0}}};
        return wide[DEF_CH_W+CH_W-1 -: CH_W];
    endfunction

    function automatic colour_t reset_colour(input int unsigned idx);
        rgb_t    d;
        colour_t c;
        d       = default_rgb(idx);
        c.red   = fit_channel(d.red);
        c.green = fit_channel(d.green);
        c.blue  = fit_channel(d.blue);
        return c;
    endfunction

    colour_t            pal_col [DEPTH];
    logic [DEPTH-1:0]   pal_blink;
    colour_t            live_col;
    logic               blink_phase;

    logic               s1_valid;
    colour_t            s1_col;
    logic               s1_blink;
    logic               s1_phase;

    // The live slot keeps its blink flag in the table but takes colour from live_col.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pal_col[i] <= reset_colour(i);
            end
            pal_blink <= '0;
        end else if (wr_en) begin
            pal_blink[wr_addr] <= wr_blink;
            if (wr_addr != LIVE_SLOT) begin
                pal_col[wr_addr] <= '{red: wr_red, green: wr_green, blue: wr_blue};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_col <= '0;
        end else if (frame_start) begin
            live_col <= '{red: live_red, green: live_green, blue: live_blue};
        end
    end

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .blink_phase(blink_phase)
    );

    // Stage 1: fetch entry state as it stood before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_col   <= '0;
            s1_blink <= 1'b0;
            s1_phase <= 1'b0;
        end else begin
            s1_valid <= pix_valid;
            s1_col   <= (pix_index == LIVE_SLOT) ? live_col : pal_col[pix_index];
            s1_blink <= pal_blink[pix_index];
            s1_phase <= blink_phase;
        end
    end

    // Stage 2: blank invalid or blinked-off pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid && !(s1_blink && s1_phase)) begin
                red   <= s1_col.red;
                green <= s1_col.green;
                blue  <= s1_col.blue;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut with BLINK_FRAMES=2.
module tb_palette_lut;

    localparam int unsigned BF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [3:0]  pix_index = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_red = '0, wr_green = '0, wr_blue = '0;
    logic        wr_blink = 1'b0;
    logic [7:0]  live_red = '0, live_green = '0, live_blue = '0;
    logic        out_valid;
    logic [7:0]  red, green, blue;

    palette_lut #(
        .INDEX_W(4), .CH_W(8), .LIVE_INDEX(5), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_index(pix_index),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue), .wr_blink(wr_blink),
        .live_red(live_red), .live_green(live_green), .live_blue(live_blue),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [24:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cycle = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [23:0] m_col [16];
    logic [15:0] m_blink;
    logic [23:0] m_live;
    logic [23:0] live_in = '0;
    int          m_cnt;
    logic        m_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_col = '{24'hffc0cb, 24'h000000, 24'hffffff, 24'h898989,
                  24'hcfcfcd, 24'h000000, 24'hd0d20e, 24'hc7f8f8,
                  24'h0313ff, 24'h000000, 24'h000000, 24'h000000,
                  24'h000000, 24'h000000, 24'h000000, 24'h000000};
        m_blink = '0;
        m_live  = '0;
        m_cnt   = 0;
        m_phase = 1'b0;
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0; pix_index = '0; wr_en = 1'b0; wr_addr = '0;
        {wr_red, wr_green, wr_blue} = '0; wr_blink = 1'b0; frame_start = 1'b0;
    endtask

    // Drive one cycle; expectation uses the model state before this edge.
    task automatic cyc(input logic v, input logic [3:0] idx,
                       input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                       input logic [23:0] wc = 24'd0, input logic wb = 1'b0,
                       input logic fs = 1'b0);
        exp_t        e;
        logic [23:0] c;
        @(negedge clk);
        pix_valid = v; pix_index = idx; wr_en = we; wr_addr = wa;
        {wr_red, wr_green, wr_blue} = wc; wr_blink = wb; frame_start = fs;
        {live_red, live_green, live_blue} = live_in;
        c = (idx == 4'd5) ? m_live : m_col[idx];
        if (!v || (m_blink[idx] && m_phase)) c = '0;
        e.due = cycle + 2;
        e.val = {v, c};
        exp_q.push_back(e);
        if (we) begin
            m_blink[wa] = wb;
            if (wa != 4'd5) m_col[wa] = wc;
        end
        if (fs) begin
            m_live = live_in;
            if (m_cnt == int'(BF) - 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (!rst) begin
                while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
                    e = exp_q.pop_front();
                    check("pix", {7'd0, out_valid, red, green, blue}, {7'd0, e.val});
                end
            end
        end
    end

    initial begin : driver
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_rgb", 32'({red, green, blue}), 32'd0);
        rst = 1'b0;

        // Default table reads and out_valid window.
        cyc(0, 0);
        cyc(1, 0); cyc(1, 2); cyc(1, 8); cyc(1, 15);
        cyc(0, 0); cyc(0, 0);

        // Write/read collision on entry 3.
        cyc(1, 3, 1, 3, 24'h112233, 0);
        cyc(1, 3);
        cyc(0, 0);

        // Live slot latched on frame_start only; writes to it keep colour.
        live_in = 24'hff0000;
        cyc(0, 0, 0, 0, 0, 0, 1);
        live_in = 24'h00ff00;
        cyc(1, 5);
        cyc(1, 5, 1, 5, 24'h445566, 0);
        cyc(1, 5, 0, 0, 0, 0, 1);
        cyc(1, 5);
        cyc(0, 0);

        // pix_valid toggling.
        cyc(1, 2); cyc(0, 2); cyc(1, 2); cyc(0, 0);

        // Async reset with pixels in flight and entry 3 rewritten.
        cyc(1, 2);
        cyc(1, 3, 1, 3, 24'haabbcc, 0);
        cyc(1, 4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_rgb", 32'({red, green, blue}), 32'd0);
        exp_q.delete();
        model_reset();
        live_in = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 3);
        cyc(0, 0);

        // Blink: entry 6 flagged, entry 7 not; six frames from a fresh phase.
        cyc(0, 0, 1, 6, 24'hd0d20e, 1);
        cyc(0, 0, 1, 7, 24'hc7f8f8, 0);
        for (int f = 0; f < 6; f++) begin
            cyc(1, 6);
            cyc(1, 7);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            live_in = 24'($urandom);
            cyc(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom),
                24'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        repeat (3) cyc(0, 0);
        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
